// File: rtl/v_alloc_pkg.sv
// rtl/v_alloc_pkg.sv - shared types, defaults and helpers for the vector port allocator
// Contents:
//   grp_state_e   per-group lifecycle: FREE, EXEC (write port busy), OP3 (spare read port reserved)
//   *_DFLT        default sizing used when the allocator is not overridden
//   op3_port_idx  odd read port of a group, used for the third operand
package v_alloc_pkg;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      EXEC = 2'd1,
      OP3  = 2'd2
   } grp_state_e;

   localparam int W_PORTS_NUM_DFLT = 4;
   localparam int R_PORTS_NUM_DFLT = 2 * W_PORTS_NUM_DFLT;
   localparam int INSTR_TYPES_DFLT = 12;

   // Each group owns read ports 2g and 2g+1; the odd one is the spare.
   function automatic int op3_port_idx(input int grp);
      return 2 * grp + 1;
   endfunction

endpackage

// File: rtl/rr_free_finder.sv
// rtl/rr_free_finder.sv - round-robin search for the first free entry from a start index
// Ports:
//   i_free     free flag per entry
//   i_start    first index examined; search wraps modulo N
//   i_excl     index never returned when i_excl_en is set
//   i_excl_en  enables the exclusion
//   o_found    some eligible entry exists
//   o_idx      first eligible entry at or after i_start (0 when none)
module rr_free_finder #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_free,
   input  logic [IW-1:0] i_start,
   input  logic [IW-1:0] i_excl,
   input  logic          i_excl_en,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;

   // N need not be a power of two, so the wrap is an explicit subtract
   // rather than dropping the carry bit.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_sum = {1'b0, i_start} + (IW+1)'(i);
         if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
         end
         w_idx = w_sum[IW-1:0];
         if (!o_found && i_free[w_idx] && !(i_excl_en && (w_idx == i_excl))) begin
            o_found = 1'b1;
            o_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/v_port_allocator.sv
// rtl/v_port_allocator.sv - round-robin write-port group allocator with op3 read-port reservation
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   instr_vld_i / instr_rdy_o per-type handshake; top bit is the config instruction
//   instr_op3_i               presented instruction needs a spare read port in a second group
//   vrf_starting_addr_vld_i   gates all non-config readiness
//   port_done_i, op3_done_i   completion pulses for EXEC and OP3 groups
//   start_o, alloc_grp_o, alloc_vld_o   combinational grant to a group
//   op3_port_sel_o, op3_vld_o           combinational op3 read-port reservation
//   grp_busy_o, all_idle_o    status from registered group state
//   err_o                     registered pulse for a done in the wrong state
module v_port_allocator
   import v_alloc_pkg::*;
#(
   parameter  int W_PORTS_NUM = W_PORTS_NUM_DFLT,
   parameter  int R_PORTS_NUM = R_PORTS_NUM_DFLT,
   parameter  int INSTR_TYPES = INSTR_TYPES_DFLT,
   localparam int GRP_W       = $clog2(W_PORTS_NUM),
   localparam int RP_W        = $clog2(R_PORTS_NUM),
   localparam int CFG_IDX     = INSTR_TYPES - 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [INSTR_TYPES-1:0] instr_vld_i,
   input  logic                   instr_op3_i,
   input  logic                   vrf_starting_addr_vld_i,
   output logic [INSTR_TYPES-1:0] instr_rdy_o,
   input  logic [W_PORTS_NUM-1:0] port_done_i,
   input  logic [W_PORTS_NUM-1:0] op3_done_i,
   output logic [W_PORTS_NUM-1:0] start_o,
   output logic [GRP_W-1:0]       alloc_grp_o,
   output logic                   alloc_vld_o,
   output logic [RP_W-1:0]        op3_port_sel_o,
   output logic                   op3_vld_o,
   output logic [W_PORTS_NUM-1:0] grp_busy_o,
   output logic                   all_idle_o,
   output logic                   err_o
);

   grp_state_e             r_state     [W_PORTS_NUM];
   grp_state_e             w_state_nxt [W_PORTS_NUM];
   logic [GRP_W-1:0]       r_ptr;
   logic [GRP_W-1:0]       w_ptr_nxt;
   logic                   r_err;
   logic                   w_err_nxt;
   logic [W_PORTS_NUM-1:0] w_free;
   logic                   w_g_found;
   logic [GRP_W-1:0]       w_g_idx;
   logic                   w_h_found;
   logic [GRP_W-1:0]       w_h_idx;
   logic [GRP_W-1:0]       w_g_succ;
   logic                   w_rdy_nc;
   logic                   w_alloc;
   logic                   w_op3_alloc;
   logic                   w_unused_cfg_vld;

   always_comb begin
      w_free = '0;
      for (int g = 0; g < W_PORTS_NUM; g++) begin
         w_free[g] = (r_state[g] == FREE);
      end
   end

   rr_free_finder #(.N(W_PORTS_NUM), .IW(GRP_W)) u_grant_finder (
      .i_free    (w_free),
      .i_start   (r_ptr),
      .i_excl    ('0),
      .i_excl_en (1'b0),
      .o_found   (w_g_found),
      .o_idx     (w_g_idx)
   );

   // Successor of the granted group: both the op3 search start and the next ptr.
   assign w_g_succ = (w_g_idx == GRP_W'(W_PORTS_NUM - 1)) ? '0 : w_g_idx + GRP_W'(1);

   rr_free_finder #(.N(W_PORTS_NUM), .IW(GRP_W)) u_op3_finder (
      .i_free    (w_free),
      .i_start   (w_g_succ),
      .i_excl    (w_g_idx),
      .i_excl_en (1'b1),
      .o_found   (w_h_found),
      .o_idx     (w_h_idx)
   );

   assign w_rdy_nc    = vrf_starting_addr_vld_i & w_g_found & (~instr_op3_i | w_h_found);
   assign w_alloc     = w_rdy_nc & (|instr_vld_i[CFG_IDX-1:0]);
   assign w_op3_alloc = w_alloc & instr_op3_i;

   // Config acceptance has no side effect here; the decoder only needs the ready.
   assign w_unused_cfg_vld = instr_vld_i[CFG_IDX];

   always_comb begin
      instr_rdy_o          = {INSTR_TYPES{w_rdy_nc}};
      instr_rdy_o[CFG_IDX] = all_idle_o;
   end

   assign start_o        = w_alloc ? ({{(W_PORTS_NUM-1){1'b0}}, 1'b1} << w_g_idx) : '0;
   assign alloc_grp_o    = w_alloc ? w_g_idx : '0;
   assign alloc_vld_o    = w_alloc;
   assign op3_vld_o      = w_op3_alloc;
   assign op3_port_sel_o = w_op3_alloc ? RP_W'(op3_port_idx(int'(w_h_idx))) : '0;
   assign grp_busy_o     = ~w_free;
   assign all_idle_o     = &w_free;
   assign err_o          = r_err;

   // Done pulses are evaluated against the current state; a new grant can
   // only target a FREE group, so it never collides with a legal release.
   always_comb begin
      w_err_nxt = 1'b0;
      for (int g = 0; g < W_PORTS_NUM; g++) begin
         w_state_nxt[g] = r_state[g];
      end
      for (int g = 0; g < W_PORTS_NUM; g++) begin
         if (port_done_i[g]) begin
            if (r_state[g] == EXEC) w_state_nxt[g] = FREE;
            else                    w_err_nxt      = 1'b1;
         end
         if (op3_done_i[g]) begin
            if (r_state[g] == OP3) w_state_nxt[g] = FREE;
            else                   w_err_nxt      = 1'b1;
         end
      end
      if (w_alloc) begin
         w_state_nxt[w_g_idx] = EXEC;
      end
      if (w_op3_alloc) begin
         w_state_nxt[w_h_idx] = OP3;
      end
      w_ptr_nxt = w_alloc ? w_g_succ : r_ptr;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int g = 0; g < W_PORTS_NUM; g++) begin
            r_state[g] <= FREE;
         end
         r_ptr <= '0;
         r_err <= 1'b0;
      end else begin
         for (int g = 0; g < W_PORTS_NUM; g++) begin
            r_state[g] <= w_state_nxt[g];
         end
         r_ptr <= w_ptr_nxt;
         r_err <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_v_port_allocator.sv
// tb/tb_v_port_allocator.sv - self-checking bench for v_port_allocator against a behavioural model
module tb_v_port_allocator;

   localparam int W  = 4;
   localparam int R  = 8;
   localparam int NT = 12;

   logic          clk;
   logic          rstn;
   logic [NT-1:0] instr_vld_i;
   logic          instr_op3_i;
   logic          vrf_starting_addr_vld_i;
   logic [NT-1:0] instr_rdy_o;
   logic [W-1:0]  port_done_i;
   logic [W-1:0]  op3_done_i;
   logic [W-1:0]  start_o;
   logic [1:0]    alloc_grp_o;
   logic          alloc_vld_o;
   logic [2:0]    op3_port_sel_o;
   logic          op3_vld_o;
   logic [W-1:0]  grp_busy_o;
   logic          all_idle_o;
   logic          err_o;

   v_port_allocator #(.W_PORTS_NUM(W), .R_PORTS_NUM(R), .INSTR_TYPES(NT)) dut (
      .clk                     (clk),
      .rstn                    (rstn),
      .instr_vld_i             (instr_vld_i),
      .instr_op3_i             (instr_op3_i),
      .vrf_starting_addr_vld_i (vrf_starting_addr_vld_i),
      .instr_rdy_o             (instr_rdy_o),
      .port_done_i             (port_done_i),
      .op3_done_i              (op3_done_i),
      .start_o                 (start_o),
      .alloc_grp_o             (alloc_grp_o),
      .alloc_vld_o             (alloc_vld_o),
      .op3_port_sel_o          (op3_port_sel_o),
      .op3_vld_o               (op3_vld_o),
      .grp_busy_o              (grp_busy_o),
      .all_idle_o              (all_idle_o),
      .err_o                   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: 0 = free, 1 = executing, 2 = op3 reservation
   int m_st [W];
   int m_ptr;
   bit m_err;

   logic [NT-1:0] ob_rdy;
   logic [W-1:0]  ob_start;
   logic [W-1:0]  ob_busy;
   logic [2:0]    ob_sel;
   logic          ob_alloc;
   logic          ob_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < W; g++) m_st[g] = 0;
      m_ptr = 0;
      m_err = 0;
   endtask

   task automatic cycle(input logic [NT-1:0] vld, input logic op3, input logic av,
                        input logic [W-1:0] pd, input logic [W-1:0] od);
      int  c, gi, hi, nst[W];
      bit  gf, hf, idle, rdy_nc, al, e;
      logic [W-1:0] busy;
      @(negedge clk);
      instr_vld_i = vld; instr_op3_i = op3; vrf_starting_addr_vld_i = av;
      port_done_i = pd;  op3_done_i  = od;
      #1;
      gf = 0; gi = 0;
      for (int i = 0; i < W; i++) begin
         c = (m_ptr + i) % W;
         if (!gf && m_st[c] == 0) begin gf = 1; gi = c; end
      end
      hf = 0; hi = 0;
      for (int j = 1; j < W; j++) begin
         c = (gi + j) % W;
         if (gf && !hf && m_st[c] == 0) begin hf = 1; hi = c; end
      end
      idle = 1; busy = '0;
      for (int g = 0; g < W; g++) if (m_st[g] != 0) begin idle = 0; busy[g] = 1'b1; end
      rdy_nc = av && gf && (!op3 || hf);
      al = rdy_nc && (vld[NT-2:0] != '0);
      chk("rdy",       instr_rdy_o,    {idle, {(NT-1){rdy_nc}}});
      chk("start",     start_o,        al ? (4'b0001 << gi) : 4'b0000);
      chk("alloc_vld", alloc_vld_o,    al);
      chk("alloc_grp", alloc_grp_o,    al ? gi : 0);
      chk("op3_vld",   op3_vld_o,      al && op3);
      chk("op3_sel",   op3_port_sel_o, (al && op3) ? 2 * hi + 1 : 0);
      chk("busy",      grp_busy_o,     busy);
      chk("all_idle",  all_idle_o,     idle);
      chk("err",       err_o,          m_err);
      ob_rdy = instr_rdy_o; ob_start = start_o; ob_busy = grp_busy_o;
      ob_sel = op3_port_sel_o; ob_alloc = alloc_vld_o; ob_err = err_o;
      @(posedge clk);
      e = 0;
      for (int g = 0; g < W; g++) nst[g] = m_st[g];
      for (int g = 0; g < W; g++) begin
         if (pd[g]) begin if (m_st[g] == 1) nst[g] = 0; else e = 1; end
         if (od[g]) begin if (m_st[g] == 2) nst[g] = 0; else e = 1; end
      end
      if (al) begin
         nst[gi] = 1;
         if (op3) nst[hi] = 2;
         m_ptr = (gi + 1) % W;
      end
      for (int g = 0; g < W; g++) m_st[g] = nst[g];
      m_err = e;
   endtask

   initial begin
      logic [W-1:0] emask, omask, pd, od;
      logic [NT-1:0] vld;
      int r;
      rstn = 1'b0;
      instr_vld_i = '0; instr_op3_i = 1'b0; vrf_starting_addr_vld_i = 1'b1;
      port_done_i = '0; op3_done_i = '0;
      model_reset();
      #3;
      chk("rst_rdy",   instr_rdy_o, 12'hfff);
      chk("rst_start", start_o, 0);
      chk("rst_alloc", alloc_vld_o, 0);
      chk("rst_grp",   alloc_grp_o, 0);
      chk("rst_op3v",  op3_vld_o, 0);
      chk("rst_sel",   op3_port_sel_o, 0);
      chk("rst_busy",  grp_busy_o, 0);
      chk("rst_idle",  all_idle_o, 1);
      chk("rst_err",   err_o, 0);
      vrf_starting_addr_vld_i = 1'b0;
      #1;
      chk("rst_rdy_gated", instr_rdy_o, 12'h800);
      @(negedge clk);
      rstn = 1'b1;

      // Four back-to-back grants walk the ring, then everything is full.
      cycle(12'h001, 0, 1, 0, 0); chk("t1_s0", ob_start, 4'b0001);
      cycle(12'h001, 0, 1, 0, 0); chk("t1_s1", ob_start, 4'b0010);
      cycle(12'h001, 0, 1, 0, 0); chk("t1_s2", ob_start, 4'b0100);
      cycle(12'h001, 0, 1, 0, 0); chk("t1_s3", ob_start, 4'b1000);
      cycle(12'h001, 0, 1, 0, 0);
      chk("t1_full_rdy", ob_rdy[0], 0);
      chk("t1_full_busy", ob_busy, 4'b1111);

      // Freed group wins regardless of the pointer.
      cycle(12'h000, 0, 1, 4'b0100, 0);
      cycle(12'h002, 0, 1, 0, 0); chk("t2_s", ob_start, 4'b0100);

      // Build FREE={1,3}, ptr=1, then an op3 grant.
      cycle(12'h000, 0, 1, 4'b0001, 0);
      cycle(12'h004, 0, 1, 0, 0); chk("t3_pre", ob_start, 4'b0001);
      cycle(12'h000, 0, 1, 4'b1010, 0);
      cycle(12'h008, 1, 1, 0, 0);
      chk("t3_s", ob_start, 4'b0010);
      chk("t3_sel", ob_sel, 7);
      cycle(12'h000, 0, 1, 0, 4'b1000);
      chk("t3_busy", ob_busy, 4'b1111);
      cycle(12'h000, 0, 1, 0, 0);
      chk("t3_freed", ob_busy, 4'b0111);

      // Only one free group: op3 stalls, plain instruction proceeds.
      cycle(12'h010, 0, 1, 0, 0); chk("t4_pre", ob_start, 4'b1000);
      cycle(12'h000, 0, 1, 4'b0001, 0);
      cycle(12'h020, 1, 1, 0, 0);
      chk("t4_stall_rdy", ob_rdy[5], 0);
      chk("t4_stall_s", ob_start, 0);
      cycle(12'h020, 0, 1, 0, 0); chk("t4_go", ob_start, 4'b0001);

      // Config waits for full drain and allocates nothing.
      cycle(12'h000, 0, 1, 4'b1011, 0);
      cycle(12'h800, 0, 1, 0, 0); chk("t5_cfg_wait", ob_rdy[11], 0);
      cycle(12'h800, 0, 1, 4'b0100, 0);
      cycle(12'h800, 0, 1, 0, 0);
      chk("t5_cfg_rdy", ob_rdy[11], 1);
      chk("t5_cfg_start", ob_start, 0);
      chk("t5_cfg_alloc", ob_alloc, 0);

      // Done on a FREE group.
      cycle(12'h000, 0, 1, 4'b0001, 0);
      cycle(12'h000, 0, 1, 0, 0); chk("t6_err", ob_err, 1);
      cycle(12'h000, 0, 1, 0, 0); chk("t6_err_clr", ob_err, 0);

      // Asynchronous reset in the middle of execution.
      cycle(12'h001, 0, 1, 0, 0);
      cycle(12'h000, 0, 1, 0, 0); chk("t7_busy_pre", ob_busy, 4'b0010);
      @(negedge clk);
      instr_vld_i = '0; port_done_i = '0; op3_done_i = '0; vrf_starting_addr_vld_i = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk("t7_rst_busy", grp_busy_o, 0);
      chk("t7_rst_idle", all_idle_o, 1);
      chk("t7_rst_rdy", instr_rdy_o, 12'hfff);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      cycle(12'h000, 0, 1, 4'b0010, 0);
      cycle(12'h000, 0, 1, 0, 0); chk("t7_stale_err", ob_err, 1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 15);
         vld = (r < NT) ? (12'h001 << r) : '0;
         emask = '0; omask = '0;
         for (int g = 0; g < W; g++) begin
            emask[g] = (m_st[g] == 1);
            omask[g] = (m_st[g] == 2);
         end
         pd = 4'($urandom) & 4'($urandom) & emask;
         od = 4'($urandom) & omask;
         if ($urandom_range(0, 9) == 0) pd = 4'($urandom);
         if ($urandom_range(0, 9) == 0) od = 4'($urandom);
         cycle(vld, 1'($urandom), ($urandom_range(0, 7) != 0), pd, od);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
